// File: rtl/clk_gate_pkg.sv
// ============================================================================
// Package : clk_gate_pkg
// Brief   : Shared types, bounds and ratio-slicing helper for clk_gate_multi.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_gate_pkg;

  localparam int c_NUM_CH_MAX = 16;
  localparam int c_M_BITS_MAX = 8;
  localparam int c_DIV_W      = c_NUM_CH_MAX * c_M_BITS_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

  // Caller passes div_m zero-extended to c_DIV_W and truncates to its own M_BITS.
  function automatic logic [c_M_BITS_MAX-1:0] m_slice(input logic [c_DIV_W-1:0] div_m,
                                                      input int c, input int m_bits);
    logic [c_DIV_W-1:0] w_sh;
    w_sh = div_m >> (c * m_bits);
    return w_sh[c_M_BITS_MAX-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gate_chan.sv
// ============================================================================
// Module : clk_gate_chan
// Brief  : One gated-clock channel: run/drain FSM, period counter, shadow
//          ratio with pending flag, and a low-transparent gate latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_gate_chan
  import clk_gate_pkg::*;
#(
  parameter int M_BITS  = 3,
  parameter int M_RESET = 0
) (
  input  logic              clkN,
  input  logic              reset,
  input  logic              i_ch_en,
  input  logic [M_BITS-1:0] i_m,
  input  logic              i_cfg_load,
  input  logic              i_align,
  output logic              o_cfg_pend,
  output logic              o_ch_active,
  output logic              o_phase_pass,
  output logic              o_clk_gate
);

  localparam logic [M_BITS-1:0] c_M_RST = M_BITS'(M_RESET);

  ch_state_e         r_state;
  logic [M_BITS-1:0] r_cnt;
  logic [M_BITS-1:0] r_m_act;
  logic [M_BITS-1:0] r_m_shd;
  logic              r_pend;
  logic              r_pass;
  logic              r_gate_lat;

  logic w_run;
  logic w_wrap;
  logic w_apply_pt;

  assign w_run      = (r_state != IDLE);
  assign w_wrap     = w_run && (r_cnt >= r_m_act);
  // Points where a pending shadow ratio may take effect.
  assign w_apply_pt = ((r_state == IDLE) && i_ch_en) || (w_run && (i_align || w_wrap));

  always_ff @(posedge clkN or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
      r_m_act <= c_M_RST;
      r_m_shd <= c_M_RST;
      r_pend  <= 1'b0;
    end else begin
      if (w_apply_pt && r_pend) r_m_act <= r_m_shd;
      if (i_cfg_load) begin
        r_m_shd <= i_m;
        r_pend  <= 1'b1;
      end else if (w_apply_pt) begin
        r_pend  <= 1'b0;
      end

      if (!w_run || i_align) begin
        r_cnt  <= '0;
        r_pass <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_pass <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_pass <= 1'b0;
      end

      case (r_state)
        IDLE:    if (i_ch_en) r_state <= RUN;
        RUN:     if (!i_ch_en) r_state <= DRAIN;
        DRAIN: begin
          if (i_ch_en)                  r_state <= RUN;
          else if (w_wrap && !i_align)  r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Latch only follows pass while clkN is low, so the AND below cannot runt.
  always_latch begin
    if (reset)      r_gate_lat = 1'b0;
    else if (!clkN) r_gate_lat = r_pass;
  end

  assign o_clk_gate   = clkN & r_gate_lat;
  assign o_cfg_pend   = r_pend;
  assign o_ch_active  = w_run;
  assign o_phase_pass = r_pass;

endmodule

`default_nettype wire

// File: rtl/clk_gate_multi.sv
// ============================================================================
// Module : clk_gate_multi
// Brief  : NUM_CH-channel programmable clock gate on clkN; optional phase
//          align input enabled by defining CLKGATE_ALIGN_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_gate_multi
  import clk_gate_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int M_BITS  = 3,
  parameter int M_RESET = 0
) (
  input  logic                     clkN,
  input  logic                     reset,
`ifdef CLKGATE_ALIGN_EN
  input  logic                     align_i,
`endif
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*M_BITS-1:0] div_m,
  input  logic                     cfg_load,
  output logic [NUM_CH-1:0]        cfg_pend_o,
  output logic [NUM_CH-1:0]        ch_active_o,
  output logic [NUM_CH-1:0]        phase_pass_o,
  output logic [NUM_CH-1:0]        clk_gate_o
);

  logic [c_DIV_W-1:0] w_div_ext;
  logic               w_align;

  assign w_div_ext = c_DIV_W'(div_m);

`ifdef CLKGATE_ALIGN_EN
  assign w_align = align_i;
`else
  assign w_align = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [M_BITS-1:0] w_m;
    assign w_m = M_BITS'(m_slice(w_div_ext, c, M_BITS));

    clk_gate_chan #(
      .M_BITS  (M_BITS),
      .M_RESET (M_RESET)
    ) u_chan (
      .clkN         (clkN),
      .reset        (reset),
      .i_ch_en      (ch_en[c]),
      .i_m          (w_m),
      .i_cfg_load   (cfg_load),
      .i_align      (w_align),
      .o_cfg_pend   (cfg_pend_o[c]),
      .o_ch_active  (ch_active_o[c]),
      .o_phase_pass (phase_pass_o[c]),
      .o_clk_gate   (clk_gate_o[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_gate_multi.sv
// ============================================================================
// Module : tb_clk_gate_multi
// Brief  : Self-checking bench for clk_gate_multi (4 channels, 3-bit ratios).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_gate_multi;

  localparam int NUM_CH = 4;
  localparam int M_BITS = 3;

  logic                     clkN;
  logic                     reset;
  logic                     align_i;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*M_BITS-1:0] div_m;
  logic                     cfg_load;
  logic [NUM_CH-1:0]        cfg_pend_o;
  logic [NUM_CH-1:0]        ch_active_o;
  logic [NUM_CH-1:0]        phase_pass_o;
  logic [NUM_CH-1:0]        clk_gate_o;

  int errs   = 0;
  int checks = 0;

  clk_gate_multi #(.NUM_CH(NUM_CH), .M_BITS(M_BITS), .M_RESET(0)) dut (
    .clkN         (clkN),
    .reset        (reset),
`ifdef CLKGATE_ALIGN_EN
    .align_i      (align_i),
`endif
    .ch_en        (ch_en),
    .div_m        (div_m),
    .cfg_load     (cfg_load),
    .cfg_pend_o   (cfg_pend_o),
    .ch_active_o  (ch_active_o),
    .phase_pass_o (phase_pass_o),
    .clk_gate_o   (clk_gate_o)
  );

  initial clkN = 1'b0;
  always #5 clkN = ~clkN;

  typedef struct {
    logic [3:0]  en;
    logic [11:0] dm;
    logic        ld;
    logic [3:0]  pend;
    logic [3:0]  act;
    logic [3:0]  pass;
    logic [3:0]  gate;
  } vec_t;

  vec_t tbl[26];

  // Returns in the clkN high phase, 2 time units after the edge.
  task automatic tick();
    @(posedge clkN);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ch_en = '0;
    cfg_load = 1'b0;
    align_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic edges_to_pass(input int ch, input int maxn, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!phase_pass_o[ch] && n < maxn);
  endtask

  initial begin
    int n;
    reset = 1'b1; ch_en = '0; div_m = '0; cfg_load = 1'b0; align_i = 1'b0;

    // en, div_m, load | pend, active, pass, gate (gate sampled in the high phase)
    tbl[0]  = '{4'b0000, 12'h003, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[6]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0001};
    tbl[7]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[10] = '{4'b0001, 12'h003, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0001};
    tbl[11] = '{4'b0001, 12'h001, 1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0001, 12'h001, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0001, 12'h001, 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[14] = '{4'b0001, 12'h001, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0001};
    tbl[15] = '{4'b0001, 12'h001, 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[16] = '{4'b0001, 12'h003, 1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b0001};
    tbl[17] = '{4'b0001, 12'h002, 1'b1, 4'b1111, 4'b0001, 4'b0001, 4'b0000};
    tbl[18] = '{4'b0001, 12'h002, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0001};
    tbl[19] = '{4'b0001, 12'h002, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[20] = '{4'b0001, 12'h002, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[21] = '{4'b0001, 12'h002, 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[22] = '{4'b0001, 12'h002, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0001};
    tbl[23] = '{4'b0001, 12'h002, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[24] = '{4'b0001, 12'h002, 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[25] = '{4'b0001, 12'h002, 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0001};

    // Reset and idle hold
    tick(); tick();
    chk("rst pend", cfg_pend_o, 4'b0000);
    chk("rst active", ch_active_o, 4'b0000);
    chk("rst pass", phase_pass_o, 4'b0000);
    chk("rst gate", clk_gate_o, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d outs", i), {cfg_pend_o, ch_active_o, phase_pass_o, clk_gate_o}, 16'h0);
    end

    // Ratio load, first periods, mid-period reload, load on a wrap edge
    for (int i = 0; i < 26; i++) begin
      ch_en = tbl[i].en; div_m = tbl[i].dm; cfg_load = tbl[i].ld;
      tick();
      chk($sformatf("row%0d pend", i), cfg_pend_o, tbl[i].pend);
      chk($sformatf("row%0d active", i), ch_active_o, tbl[i].act);
      chk($sformatf("row%0d pass", i), phase_pass_o, tbl[i].pass);
      chk($sformatf("row%0d gate", i), clk_gate_o, tbl[i].gate);
    end
    cfg_load = 1'b0;

    // Drain: ch1 M=5, enable dropped at cnt=2
    do_reset();
    div_m = 12'(5 << 3); cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("drain pend", cfg_pend_o, 4'b1111);
    ch_en = 4'b0010;
    tick();
    chk("drain start active", ch_active_o, 4'b0010);
    tick(); tick();
    ch_en = 4'b0000;
    tick();
    chk("drain active", 32'(ch_active_o[1]), 1);
    tick(); tick();
    chk("drain pre pass", 32'(phase_pass_o[1]), 0);
    tick();
    chk("drain last pass", 32'(phase_pass_o[1]), 1);
    chk("drain to idle", 32'(ch_active_o[1]), 0);
    tick();
    chk("drain last gate", 32'(clk_gate_o[1]), 1);
    chk("drain pass clr", 32'(phase_pass_o[1]), 0);
    tick();
    chk("drain gate off", 32'(clk_gate_o[1]), 0);
    ch_en = 4'b0010;
    tick();
    edges_to_pass(1, 20, n);
    chk("restart latency", n, 6);
    // Brief drop and return before the wrap keeps the period unbroken
    tick();
    ch_en = 4'b0000;
    tick();
    chk("redrain active", 32'(ch_active_o[1]), 1);
    ch_en = 4'b0010;
    tick();
    chk("rerun active", 32'(ch_active_o[1]), 1);
    edges_to_pass(1, 20, n);
    chk("unbroken period", n, 3);

    // ch0 M=0 and ch1 M=7 side by side
    do_reset();
    div_m = 12'(7 << 3); cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    ch_en = 4'b0011;
    tick();
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] exp_pass;
      logic [3:0] exp_gate;
      tick();
      exp_pass = {2'b00, (k % 8 == 0), 1'b1};
      exp_gate = {2'b00, (k % 8 == 1 && k > 1), (k >= 2)};
      chk($sformatf("indep%0d pass", k), phase_pass_o, exp_pass);
      chk($sformatf("indep%0d gate", k), clk_gate_o, exp_gate);
    end
    @(negedge clkN); #1;
    chk("low phase gate", clk_gate_o, 4'b0000);
    tick();
    chk("high phase gate0", 32'(clk_gate_o[0]), 1);

    // Reset in the middle of a high phase
    reset = 1'b1;
    #1;
    chk("midrst gate", clk_gate_o, 4'b0000);
    chk("midrst pass", phase_pass_o, 4'b0000);
    chk("midrst active", ch_active_o, 4'b0000);
    tick();
    reset = 1'b0;
    tick();
    chk("post rst pass", phase_pass_o, 4'b0000);
    chk("post rst gate", clk_gate_o, 4'b0000);
    tick();
    chk("post rst pass2", phase_pass_o, 4'b0011);
    chk("post rst gate2", clk_gate_o, 4'b0000);
    tick();
    chk("post rst gate3", clk_gate_o, 4'b0011);

`ifdef CLKGATE_ALIGN_EN
    begin
      int f0;
      int f1;
      do_reset();
      div_m = 12'((5 << 3) | 3); cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      ch_en = 4'b0011;
      tick(); tick(); tick();
      align_i = 1'b1;
      tick();
      align_i = 1'b0;
      chk("align pass", phase_pass_o, 4'b0000);
      f0 = 0; f1 = 0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (phase_pass_o[0] && f0 == 0) f0 = k;
        if (phase_pass_o[1] && f1 == 0) f1 = k;
      end
      chk("align ch0 first", f0, 4);
      chk("align ch1 first", f1, 6);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
